overlay_box_scheduler: RTL and testbench

Collects bounding-box updates from three requesters: the face detector, the eye detector and the eye tracker. A round-robin arbiter writes them into a 5-slot shadow bank, and the bank commits atomically to the active bank at each frame_sync. The active bank drives the LCD overlay compare logic, so box coordinates never change mid-frame. Slots not refreshed within TIMEOUT_FRAMES frames are blanked.

---
 rtl/overlay_box_scheduler.sv | 166 ++++++++++++++++
 tb/tb_overlay_box_scheduler.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/overlay_box_scheduler.sv
// Overlay box scheduler: three requesters write bounding boxes through a
// round-robin arbiter into a shadow bank that commits to the active bank on
// frame_sync, so the LCD overlay never sees coordinates change mid-frame.

// One overlay slot: shadow/active pair, pending flag and staleness age.
module overlay_box_slot #(
  parameter int          TIMEOUT_FRAMES = 8,
  parameter logic [10:0] OFF_COORD      = 11'h7FF
) (
  input  logic        lcd_clk,
  input  logic        sys_rst_n,
  input  logic        frame_sync,
  input  logic        wr_en,
  input  logic [43:0] wr_box,
  output logic [43:0] box_out,
  output logic        valid
);
  localparam logic [3:0]  AGE_MAX = 4'(TIMEOUT_FRAMES);
  localparam logic [43:0] OFF_BOX = {4{OFF_COORD}};

  logic [43:0] shadow;
  logic [43:0] active;
  logic        pending;
  logic [3:0]  age;

  // Commit on frame_sync uses the pre-edge shadow; a write on the same edge
  // lands in shadow and re-arms pending for the next frame.
  always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      shadow  <= OFF_BOX;
      active  <= OFF_BOX;
      pending <= 1'b0;
      age     <= AGE_MAX;
      valid   <= 1'b0;
    end else begin
      if (frame_sync) begin
        pending <= 1'b0;
        if (pending) begin
          active <= shadow;
          age    <= 4'd0;
          valid  <= 1'b1;
        end else if (age < AGE_MAX) begin
          age <= age + 4'd1;
          if (age + 4'd1 == AGE_MAX) valid <= 1'b0;
        end
      end
      if (wr_en) begin
        shadow  <= wr_box;
        pending <= 1'b1;
      end
    end
  end

  // Invalid slots park every field at a coordinate no pixel can match.
  assign box_out = valid ? active : OFF_BOX;
endmodule

module overlay_box_scheduler #(
  parameter int          H_CMOS         = 640,
  parameter int          V_CMOS         = 480,
  parameter int          TIMEOUT_FRAMES = 8,
  parameter logic [10:0] OFF_COORD      = 11'h7FF
) (
  input  logic         lcd_clk,
  input  logic         sys_rst_n,
  input  logic         frame_sync,
  input  logic [2:0]   req,
  input  logic [2:0]   sel,
  input  logic [131:0] box_in,
  output logic [2:0]   ack,
  output logic [2:0]   err,
  output logic [219:0] box_act,
  output logic [4:0]   slot_valid,
  output logic         commit
);
  localparam int NUM_SLOTS = 5;

  typedef struct packed {
    logic [10:0] up;
    logic [10:0] down;
    logic [10:0] left;
    logic [10:0] right;
  } box_t;

  logic [2:0]  elig;
  logic [1:0]  rr_ptr;
  logic        gnt_vld;
  logic [1:0]  gnt_src;
  logic [2:0]  idx;
  box_t        gnt_box;
  logic [2:0]  gnt_slot;
  logic        gnt_bad;
  logic        wr_en;
  logic        unused_sel;
  logic [NUM_SLOTS-1:0][43:0] slot_box;

  // Face requests have no eye select.
  assign unused_sel = sel[0];

  // A source whose ack is showing is masked so a lingering req cannot re-win.
  assign elig = req & ~ack;

  // Round-robin pick starting at rr_ptr.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_src = 2'd0;
    idx     = 3'd0;
    for (int k = 0; k < 3; k++) begin
      idx = {1'b0, rr_ptr} + 3'(k);
      if (idx >= 3'd3) idx = idx - 3'd3;
      if (!gnt_vld && elig[idx[1:0]]) begin
        gnt_vld = 1'b1;
        gnt_src = idx[1:0];
      end
    end
  end

  // Route the granted source's box and slot, then bounds-check it.
  always_comb begin
    case (gnt_src)
      2'd0:    begin gnt_box = box_t'(box_in[43:0]);   gnt_slot = 3'd0; end
      2'd1:    begin gnt_box = box_t'(box_in[87:44]);  gnt_slot = 3'd1 + {2'b00, sel[1]}; end
      default: begin gnt_box = box_t'(box_in[131:88]); gnt_slot = 3'd3 + {2'b00, sel[2]}; end
    endcase
    gnt_bad = (gnt_box.up > gnt_box.down) || (gnt_box.left > gnt_box.right) ||
              (gnt_box.down >= 11'(V_CMOS)) || (gnt_box.right >= 11'(H_CMOS));
  end

  assign wr_en = gnt_vld && !gnt_bad;

  // Registered handshake pulses, commit strobe and arbiter pointer.
  always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ack    <= 3'b000;
      err    <= 3'b000;
      commit <= 1'b0;
      rr_ptr <= 2'd0;
    end else begin
      ack    <= 3'b000;
      err    <= 3'b000;
      commit <= frame_sync;
      if (gnt_vld) begin
        ack[gnt_src] <= 1'b1;
        err[gnt_src] <= gnt_bad;
        rr_ptr       <= (gnt_src == 2'd2) ? 2'd0 : gnt_src + 2'd1;
      end
    end
  end

  for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
    overlay_box_slot #(
      .TIMEOUT_FRAMES(TIMEOUT_FRAMES),
      .OFF_COORD     (OFF_COORD)
    ) u_slot (
      .lcd_clk   (lcd_clk),
      .sys_rst_n (sys_rst_n),
      .frame_sync(frame_sync),
      .wr_en     (wr_en && (gnt_slot == 3'(s))),
      .wr_box    (gnt_box),
      .box_out   (slot_box[s]),
      .valid     (slot_valid[s])
    );
  end

  assign box_act = slot_box;
endmodule

// File: tb/tb_overlay_box_scheduler.sv
// Bench for overlay_box_scheduler: directed scenarios with literal
// expectations, then randomized handshakes checked every cycle against a
// transaction-level model of arbitration, validation, commit and ageing.
module tb_overlay_box_scheduler;
  localparam int          H   = 640;
  localparam int          V   = 480;
  localparam int          T   = 8;
  localparam logic [10:0] OFF = 11'h7FF;
  localparam logic [43:0] OFF4 = {4{OFF}};

  logic         lcd_clk = 1'b0;
  logic         sys_rst_n = 1'b0;
  logic         frame_sync = 1'b0;
  logic [2:0]   req = '0;
  logic [2:0]   sel = '0;
  logic [131:0] box_in = '0;
  logic [2:0]   ack, err;
  logic [219:0] box_act;
  logic [4:0]   slot_valid;
  logic         commit;

  int n_tests = 0;
  int n_fail  = 0;

  overlay_box_scheduler dut (
    .lcd_clk(lcd_clk), .sys_rst_n(sys_rst_n), .frame_sync(frame_sync),
    .req(req), .sel(sel), .box_in(box_in), .ack(ack), .err(err),
    .box_act(box_act), .slot_valid(slot_valid), .commit(commit)
  );

  always #5 lcd_clk = ~lcd_clk;

  task automatic check(input string name, input logic [219:0] got, input logic [219:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [43:0] mk(input int u, input int d, input int l, input int r);
    return {11'(u), 11'(d), 11'(l), 11'(r)};
  endfunction

  function automatic bit ok_box(input logic [43:0] b);
    return (b[43:33] <= b[32:22]) && (b[21:11] <= b[10:0]) &&
           (int'(b[32:22]) < V) && (int'(b[10:0]) < H);
  endfunction

  // ---------------- reference model ----------------
  logic [43:0] m_sh [5];
  logic [43:0] m_act[5];
  int          m_age[5];
  logic [4:0]  m_pend, m_vld;
  logic [2:0]  m_ack, m_err;
  logic        m_commit;
  int          m_ptr;

  task automatic m_reset();
    for (int s = 0; s < 5; s++) begin
      m_sh[s] = OFF4; m_act[s] = OFF4; m_age[s] = T;
    end
    m_pend = '0; m_vld = '0; m_ack = '0; m_err = '0; m_commit = 1'b0; m_ptr = 0;
  endtask

  task automatic m_step();
    int g, slot;
    logic [43:0] b;
    logic [2:0] elig;
    g = -1; slot = 0; b = '0;
    elig = req & ~m_ack;
    for (int k = 0; k < 3; k++)
      if (g < 0 && elig[(m_ptr + k) % 3]) g = (m_ptr + k) % 3;
    m_ack = '0; m_err = '0;
    if (g >= 0) begin
      m_ptr = (g + 1) % 3;
      m_ack[g] = 1'b1;
      b = box_in[44*g +: 44];
      slot = (g == 0) ? 0 : (g == 1) ? 1 + int'(sel[1]) : 3 + int'(sel[2]);
      if (!ok_box(b)) m_err[g] = 1'b1;
    end
    m_commit = frame_sync;
    if (frame_sync) begin
      for (int s = 0; s < 5; s++) begin
        if (m_pend[s]) begin
          m_act[s] = m_sh[s]; m_age[s] = 0; m_vld[s] = 1'b1;
        end else begin
          m_age[s] = (m_age[s] + 1 > T) ? T : m_age[s] + 1;
          if (m_age[s] == T) m_vld[s] = 1'b0;
        end
      end
      m_pend = '0;
    end
    if (g >= 0 && !m_err[g]) begin
      m_sh[slot] = b; m_pend[slot] = 1'b1;
    end
  endtask

  function automatic logic [219:0] m_box_act();
    logic [219:0] o;
    for (int s = 0; s < 5; s++) o[44*s +: 44] = m_vld[s] ? m_act[s] : OFF4;
    return o;
  endfunction

  initial begin
    m_reset();
    forever begin
      @(posedge lcd_clk or negedge sys_rst_n);
      if (!sys_rst_n) m_reset();
      else m_step();
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge lcd_clk);
      check("m_ack", ack, m_ack);
      check("m_err", err, m_err);
      check("m_commit", commit, m_commit);
      check("m_valid", slot_valid, m_vld);
      check("m_box_act", box_act, m_box_act());
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge lcd_clk); #1;
  endtask

  task automatic pulse_fs();
    frame_sync = 1'b1; tick(); frame_sync = 1'b0;
  endtask

  task automatic req_wait(input int k);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      tick();
      if (ack[k]) got = 1'b1;
    end
    check($sformatf("ack_seen%0d", k), 220'(got), 220'(1));
  endtask

  function automatic int pick(input int lim);
    case ($urandom_range(0, 4))
      0:       return 0;
      1:       return lim - 1;
      2:       return lim;
      default: return int'($urandom_range(0, lim - 1));
    endcase
  endfunction

  task automatic new_req(input int k);
    int u, d, l, r, t;
    u = pick(V); d = pick(V); l = pick(H); r = pick(H);
    if ($urandom_range(0, 1) == 1) begin
      if (u > d) begin t = u; u = d; d = t; end
      if (l > r) begin t = l; l = r; r = t; end
    end
    box_in[44*k +: 44] = mk(u, d, l, r);
    sel[k] = 1'($urandom_range(0, 1));
    req[k] = 1'b1;
  endtask

  task automatic run_random(input int cycles);
    bit stale[3];
    for (int k = 0; k < 3; k++) stale[k] = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      tick();
      if (c == cycles / 2) begin
        #2 sys_rst_n = 1'b0;
        #2 sys_rst_n = 1'b1;
      end
      frame_sync = ($urandom_range(0, 15) == 0);
      for (int k = 0; k < 3; k++) begin
        if (stale[k]) begin
          req[k] = 1'b0; stale[k] = 1'b0;
        end else if (req[k] && ack[k]) begin
          case ($urandom_range(0, 2))
            0:       stale[k] = 1'b1;
            1:       new_req(k);
            default: req[k] = 1'b0;
          endcase
        end else if (!req[k] && $urandom_range(0, 3) == 0) begin
          new_req(k);
        end
      end
    end
    frame_sync = 1'b0; req = '0;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    repeat (3) @(posedge lcd_clk);
    #1 sys_rst_n = 1'b1;
    tick();
    check("rst_valid", slot_valid, 5'b0);
    check("rst_box", box_act, {20{OFF}});
    check("rst_ack", ack, 3'b0);
    check("rst_commit", commit, 1'b0);
    pulse_fs();
    check("fs0_commit", commit, 1'b1);
    check("fs0_valid", slot_valid, 5'b0);
    check("fs0_box", box_act, {20{OFF}});
    tick();
    check("fs0_commit_drop", commit, 1'b0);

    // Face write, visible only after the next commit
    box_in[43:0] = mk(100, 300, 200, 400); req[0] = 1'b1;
    req_wait(0); req[0] = 1'b0;
    check("face_err", err[0], 1'b0);
    check("face_pre_box", box_act[43:0], OFF4);
    tick(); tick();
    check("face_hold_box", box_act[43:0], OFF4);
    check("face_hold_valid", slot_valid[0], 1'b0);
    pulse_fs();
    check("face_box", box_act[43:0], mk(100, 300, 200, 400));
    check("face_valid", slot_valid[0], 1'b1);

    // Rejects on slot 2, equal-bound accept on slot 1
    sel[1] = 1'b1; box_in[87:44] = mk(50, 40, 10, 20); req[1] = 1'b1;
    req_wait(1); req[1] = 1'b0;
    check("rej_updown_err", err[1], 1'b1);
    box_in[87:44] = mk(10, 20, 30, 640); req[1] = 1'b1;
    req_wait(1); req[1] = 1'b0;
    check("rej_right_err", err[1], 1'b1);
    sel[1] = 1'b0; box_in[87:44] = mk(479, 479, 639, 639); req[1] = 1'b1;
    req_wait(1); req[1] = 1'b0;
    check("edge_err", err[1], 1'b0);
    pulse_fs();
    check("rej_slot2_valid", slot_valid[2], 1'b0);
    check("edge_slot1_valid", slot_valid[1], 1'b1);
    check("edge_slot1_box", box_act[87:44], mk(479, 479, 639, 639));

    // Grant coincident with frame_sync
    sel[2] = 1'b0; box_in[131:88] = mk(10, 20, 30, 40); req[2] = 1'b1;
    req_wait(2); req[2] = 1'b0;
    tick();
    box_in[131:88] = mk(11, 21, 31, 41); req[2] = 1'b1; frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0; req[2] = 1'b0;
    check("coin_ack", ack[2], 1'b1);
    check("coin_commit", commit, 1'b1);
    check("coin_old_box", box_act[175:132], mk(10, 20, 30, 40));
    tick();
    pulse_fs();
    check("coin_new_box", box_act[175:132], mk(11, 21, 31, 41));

    // Timeout of slot 3
    for (int i = 1; i <= 8; i++) begin
      tick();
      pulse_fs();
      check($sformatf("age%0d_valid", i), slot_valid[3], (i < 8) ? 1'b1 : 1'b0);
      check($sformatf("age%0d_box", i), box_act[175:132], (i < 8) ? mk(11, 21, 31, 41) : OFF4);
    end

    // All three requesting continuously from reset
    sys_rst_n = 1'b0; tick(); sys_rst_n = 1'b1; tick();
    box_in = {mk(1, 2, 3, 4), mk(5, 6, 7, 8), mk(9, 10, 11, 12)}; sel = 3'b000;
    req = 3'b111;
    for (int i = 0; i < 6; i++) begin
      logic [2:0] exp_ack;
      tick();
      exp_ack = 3'b001 << (i % 3);
      check($sformatf("rr_ack%0d", i), ack, exp_ack);
    end
    req = 3'b000;
    tick(); tick();

    // Reset during an in-flight ack
    box_in[43:0] = mk(0, 0, 0, 0); req[0] = 1'b1;
    tick();
    check("mid_ack_pre", ack[0], 1'b1);
    #2 sys_rst_n = 1'b0;
    #1;
    check("mid_ack_lost", ack, 3'b0);
    check("mid_valid", slot_valid, 5'b0);
    req[0] = 1'b0;
    tick();
    sys_rst_n = 1'b1;
    tick();

    run_random(4000);
    tick(); tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
